ucaspian_step_sched: RTL

- Top-level time-step scheduler for the uCaspian core.
- Accepts host commands (run N steps, clear activity, clear configuration) and sequences the axon, synapse and neuron units through them.
- Drives the shared enable/next_step/clear_act/clear_config controls and aggregates each unit's step_done/clear_done.
- A step or clear is complete only when every unit reports done.

---
 rtl/ucaspian_step_sched_if.sv | 49 ++++
 rtl/ucaspian_step_sched.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ucaspian_step_sched_if.sv
// ucaspian_step_sched_if
// Groups the host command channel and the unit sequencing controls of the
// uCaspian time-step scheduler into one bundle.
//
// Signals:
//   cmd_vld / cmd_rdy / cmd_op / cmd_steps : host command handshake and operands
//   halt                                   : host request to stop a RUN early
//   step_done_vec / clear_done_vec         : per-unit completion flags
//   enable / next_step                     : unit run controls
//   clear_act / clear_config               : unit clear requests (levels)
//   busy / cmd_done / cmd_err              : scheduler status back to the host
//   step_count / steps_left                : RUN progress counters
//
// Modports:
//   master : host/unit side (drives commands and done flags)
//   slave  : scheduler side
interface ucaspian_step_sched_if #(
    parameter int N_UNITS = 3,
    parameter int CNT_W   = 16
);
    logic               cmd_vld;
    logic               cmd_rdy;
    logic [1:0]         cmd_op;
    logic [CNT_W-1:0]   cmd_steps;
    logic               halt;
    logic [N_UNITS-1:0] step_done_vec;
    logic [N_UNITS-1:0] clear_done_vec;
    logic               enable;
    logic               next_step;
    logic               clear_act;
    logic               clear_config;
    logic               busy;
    logic               cmd_done;
    logic               cmd_err;
    logic [CNT_W-1:0]   step_count;
    logic [CNT_W-1:0]   steps_left;

    modport master (
        output cmd_vld, cmd_op, cmd_steps, halt, step_done_vec, clear_done_vec,
        input  cmd_rdy, enable, next_step, clear_act, clear_config,
               busy, cmd_done, cmd_err, step_count, steps_left
    );

    modport slave (
        input  cmd_vld, cmd_op, cmd_steps, halt, step_done_vec, clear_done_vec,
        output cmd_rdy, enable, next_step, clear_act, clear_config,
               busy, cmd_done, cmd_err, step_count, steps_left
    );
endinterface

// File: rtl/ucaspian_step_sched.sv
// ucaspian_step_sched
// Top-level time-step scheduler for the uCaspian core. Accepts host commands
// (RUN n steps, CLEAR_ACT, CLEAR_CONFIG) and sequences the axon, synapse and
// neuron units through them, completing a step or clear only once every unit
// has reported done.
//
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high reset
//   bus   : ucaspian_step_sched_if.slave, command channel + unit controls
//
// Parameters:
//   N_UNITS       : number of sequenced units (width of the done vectors)
//   CNT_W         : width of the step-count operand and counters
//   SETTLE_CYCLES : cycles after next_step during which step_done_vec is
//                   ignored, since units may still show the previous step's done
module ucaspian_step_sched #(
    parameter int N_UNITS       = 3,
    parameter int CNT_W         = 16,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    ucaspian_step_sched_if.slave bus
);

    localparam int SET_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

    localparam logic [1:0] OP_RUN       = 2'd0;
    localparam logic [1:0] OP_CLEAR_ACT = 2'd1;
    localparam logic [1:0] OP_CLEAR_CFG = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STEP,
        S_SETTLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   step_count_r, step_count_n;
    logic [CNT_W-1:0]   steps_left_r, steps_left_n;
    logic [SET_W-1:0]   settle_cnt, settle_cnt_n;
    logic               halt_pending, halt_pending_n;
    logic               err_r, err_n;
    logic               clr_cfg_r, clr_cfg_n;
    logic               clr_first, clr_first_n;

    // State and datapath registers. Reset returns to IDLE at once, and every
    // unit control is decoded from the state, so clears and enable drop
    // without waiting for the units.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            step_count_r <= '0;
            steps_left_r <= '0;
            settle_cnt   <= '0;
            halt_pending <= 1'b0;
            err_r        <= 1'b0;
            clr_cfg_r    <= 1'b0;
            clr_first    <= 1'b0;
        end else begin
            state        <= state_n;
            step_count_r <= step_count_n;
            steps_left_r <= steps_left_n;
            settle_cnt   <= settle_cnt_n;
            halt_pending <= halt_pending_n;
            err_r        <= err_n;
            clr_cfg_r    <= clr_cfg_n;
            clr_first    <= clr_first_n;
        end
    end

    // Next-state and datapath update. A step ends when all units report done
    // in WAIT. A halt seen during the step (including its final WAIT cycle)
    // ends the RUN after that step completes.
    always_comb begin
        state_n        = state;
        step_count_n   = step_count_r;
        steps_left_n   = steps_left_r;
        settle_cnt_n   = settle_cnt;
        halt_pending_n = halt_pending;
        err_n          = err_r;
        clr_cfg_n      = clr_cfg_r;
        clr_first_n    = clr_first;

        case (state)
            S_IDLE: begin
                halt_pending_n = 1'b0;
                if (bus.cmd_vld) begin
                    err_n = 1'b0;
                    case (bus.cmd_op)
                        OP_RUN: begin
                            step_count_n = '0;
                            steps_left_n = bus.cmd_steps;
                            state_n      = (bus.cmd_steps == '0) ? S_DONE : S_STEP;
                        end
                        OP_CLEAR_ACT: begin
                            clr_cfg_n   = 1'b0;
                            clr_first_n = 1'b1;
                            state_n     = S_CLEAR;
                        end
                        OP_CLEAR_CFG: begin
                            clr_cfg_n   = 1'b1;
                            clr_first_n = 1'b1;
                            state_n     = S_CLEAR;
                        end
                        default: begin
                            err_n   = 1'b1;
                            state_n = S_DONE;
                        end
                    endcase
                end
            end
            // The done flags seen in the first cycle of a clear are left over
            // from before the request, so they are skipped.
            S_CLEAR: begin
                clr_first_n = 1'b0;
                if (!clr_first && (&bus.clear_done_vec)) begin
                    state_n = S_DONE;
                end
            end
            S_STEP: begin
                halt_pending_n = halt_pending | bus.halt;
                settle_cnt_n   = SET_W'(SETTLE_CYCLES);
                state_n        = (SETTLE_CYCLES == 0) ? S_WAIT : S_SETTLE;
            end
            S_SETTLE: begin
                halt_pending_n = halt_pending | bus.halt;
                settle_cnt_n   = settle_cnt - SET_W'(1);
                if (settle_cnt <= SET_W'(1)) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                halt_pending_n = halt_pending | bus.halt;
                if (&bus.step_done_vec) begin
                    step_count_n = step_count_r + CNT_W'(1);
                    steps_left_n = steps_left_r - CNT_W'(1);
                    if ((steps_left_r == CNT_W'(1)) || halt_pending || bus.halt) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_STEP;
                    end
                end
            end
            S_DONE: begin
                halt_pending_n = 1'b0;
                state_n        = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign bus.cmd_rdy      = (state == S_IDLE);
    assign bus.busy         = (state != S_IDLE);
    assign bus.enable       = (state == S_STEP) || (state == S_SETTLE) || (state == S_WAIT);
    assign bus.next_step    = (state == S_STEP);
    assign bus.clear_act    = (state == S_CLEAR) && !clr_cfg_r;
    assign bus.clear_config = (state == S_CLEAR) && clr_cfg_r;
    assign bus.cmd_done     = (state == S_DONE);
    assign bus.cmd_err      = (state == S_DONE) && err_r;
    assign bus.step_count   = step_count_r;
    assign bus.steps_left   = steps_left_r;

endmodule
